seven_segment_scanner: RTL and testbench
========================================

# seven_segment_scanner

Parametrised multiplexed seven-segment display driver that scans NUM_DIGITS common-anode digits. Adds tear-free double-buffered value loading over a valid/ready handshake, per-digit enable and decimal points, leading-zero blanking, hex/decimal glyph mode and PWM brightness. It sits between the debug/status datapath and the board's `an`/`cat` pins.

## Interface
- NUM_DIGITS, 8, number of digits scanned (1..16)
- COUNT_PERIOD, 100000, clock cycles each digit is selected (>= 2)
- PWM_BITS, 4, brightness resolution in bits (1..8)
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- val_in  in  4*NUM_DIGITS  nibble per digit; digit i = val_in[4i+3:4i], digit 0 rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit
- en_in  in  NUM_DIGITS  digit enable per digit
- load_valid  in  1  val_in/dp_in/en_in are valid
- load_ready  out  1  pending buffer empty, load will be accepted
- hex_mode  in  1  1: glyphs 0-F; 0: nibbles 10-15 show "-"
- blank_zeros  in  1  suppress leading zeros
- brightness  in  PWM_BITS  0 = dark, all-ones = full on
- cat  out  7  active-low segments {g,f,e,d,c,b,a}
- dp_n  out  1  active-low decimal point
- an  out  NUM_DIGITS  active-low digit selects, at most one low
- frame_tick  out  1  one-cycle pulse at each frame boundary

## Operation
- Registers: pending (val, dp, en, full flag), active (val, dp, en), 32-bit prescaler, digit index, PWM counter.
- load_ready = ~pending_full. Handshake fires on load_valid && load_ready; pending captures inputs, pending_full set.
- Frame boundary: prescaler == COUNT_PERIOD-1 and index == NUM_DIGITS-1. At that edge: prescaler, index <= 0; if pending_full, active <= pending and pending_full cleared; frame_tick <= 1 (else 0).
- Otherwise prescaler increments; at COUNT_PERIOD-1 it wraps to 0 and index increments.
- Load and boundary on same edge: load is accepted only if pending was empty before the edge; that load is not transferred until the next boundary.
- PWM counter free-runs mod 2^PWM_BITS. Lit = (brightness all-ones) or (pwm_cnt < brightness).
- Digit i shown iff active en[i], lit, and not blanked. Blanked iff blank_zeros, i != 0, and active nibbles i..NUM_DIGITS-1 all zero.
- Shown: an bit i low, cat = glyph(nibble, hex_mode), dp_n = ~active dp[i]. Not shown: an all ones, cat all ones, dp_n 1.
- Glyphs (active-high a..g): 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 all, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg; dash = g.
- Reset: active val 0, dp 0, en all ones, pending empty; counters 0.

## Timing
- Reset values while rst_n low: an all ones, cat 7'h7F, dp_n 1, frame_tick 0, load_ready 1.
- an/cat/dp_n registered: pins reflect index/active/PWM state with one-cycle latency.
- Frame period NUM_DIGITS*COUNT_PERIOD cycles; each digit dwells exactly COUNT_PERIOD cycles.
- Accepted load appears on pins at digit 0 of the first frame after the next boundary, never mid-frame.
- load_ready low from the cycle after acceptance until the cycle after the transferring boundary.
- Reset mid-frame discards pending and active contents; scanning restarts at digit 0.

## Structure
- Package seven_segment_pkg: glyph constants (GLYPH_0..GLYPH_F, GLYPH_DASH, GLYPH_BLANK) and NUM_DIGITS_MAX = 16.
- One sub-module seg_glyph_decoder: combinational nibble + hex_mode to 7-bit active-high segments.
- Index width $clog2(NUM_DIGITS), minimum 1.

## Test plan
- NUM_DIGITS=4, COUNT_PERIOD=4, brightness=all-ones, load val 16'h12AF, hex_mode=1 -> after next boundary, an cycles 1110,1101,1011,0111 every 4 cycles showing F, A, 2, 1; frame_tick every 16 cycles.
- Same, hex_mode=0 -> digits 0 and 1 show dash (cat 7'b0111111), digits 2-3 show 2 and 1.
- Load 16'h0050, blank_zeros=1 -> digits 3,2 an high whole dwell; digit 1 shows 5; digit 0 shows 0.
- Second load_valid while pending full -> load_ready 0, value ignored; accepted after boundary; mid-frame pins never show the new value.
- PWM_BITS=4, brightness=4 -> an low in exactly 4 of every 16 cycles of a dwell; brightness=0 -> an all ones.
- Assert rst_n low mid-frame with pending full -> pins go to reset values immediately; after release load_ready=1, display shows 0 on digit 0 scan.

Source files
------------

// File: rtl/seven_segment_scanner_pkg.sv
// Shared constants for the seven-segment scanner: glyph patterns and limits.
// Glyphs are active-high in {g,f,e,d,c,b,a} order (bit 0 = segment a).
package seven_segment_pkg;

   localparam int NUM_DIGITS_MAX = 16;

   localparam logic [6:0] GLYPH_0     = 7'h3F; // abcdef
   localparam logic [6:0] GLYPH_1     = 7'h06; // bc
   localparam logic [6:0] GLYPH_2     = 7'h5B; // abdeg
   localparam logic [6:0] GLYPH_3     = 7'h4F; // abcdg
   localparam logic [6:0] GLYPH_4     = 7'h66; // bcfg
   localparam logic [6:0] GLYPH_5     = 7'h6D; // acdfg
   localparam logic [6:0] GLYPH_6     = 7'h7D; // acdefg
   localparam logic [6:0] GLYPH_7     = 7'h07; // abc
   localparam logic [6:0] GLYPH_8     = 7'h7F; // all
   localparam logic [6:0] GLYPH_9     = 7'h6F; // abcdfg
   localparam logic [6:0] GLYPH_A     = 7'h77; // abcefg
   localparam logic [6:0] GLYPH_B     = 7'h7C; // cdefg
   localparam logic [6:0] GLYPH_C     = 7'h39; // adef
   localparam logic [6:0] GLYPH_D     = 7'h5E; // bcdeg
   localparam logic [6:0] GLYPH_E     = 7'h79; // adefg
   localparam logic [6:0] GLYPH_F     = 7'h71; // aefg
   localparam logic [6:0] GLYPH_DASH  = 7'h40; // g
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Load port of the scanner: per-digit value/dp/enable plus valid/ready.
// Handshake: a transfer happens on a clock edge where load_valid and
// load_ready are both high; the master holds val_in/dp_in/en_in stable while
// load_valid is high and ready is low, and ready never depends on valid.
interface seven_segment_scanner_if #(
   parameter int NUM_DIGITS = 8
);
   logic [4*NUM_DIGITS-1:0] val_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   en_in;
   logic                    load_valid;
   logic                    load_ready;

   modport master (
      output val_in, dp_in, en_in, load_valid,
      input  load_ready
   );

   modport slave (
      input  val_in, dp_in, en_in, load_valid,
      output load_ready
   );
endinterface

// File: rtl/seven_segment_scanner_glyph_decoder.sv
// Combinational nibble-to-segment decoder; in decimal mode 10..15 render as a dash.
module seg_glyph_decoder
   import seven_segment_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       hex_mode_i,
   output logic [6:0] seg_o
);

   // Table lookup, then override non-decimal nibbles when hex glyphs are off
   always_comb begin
      seg_o = GLYPH_BLANK;
      case (nibble_i)
         4'h0: seg_o = GLYPH_0;
         4'h1: seg_o = GLYPH_1;
         4'h2: seg_o = GLYPH_2;
         4'h3: seg_o = GLYPH_3;
         4'h4: seg_o = GLYPH_4;
         4'h5: seg_o = GLYPH_5;
         4'h6: seg_o = GLYPH_6;
         4'h7: seg_o = GLYPH_7;
         4'h8: seg_o = GLYPH_8;
         4'h9: seg_o = GLYPH_9;
         4'hA: seg_o = GLYPH_A;
         4'hB: seg_o = GLYPH_B;
         4'hC: seg_o = GLYPH_C;
         4'hD: seg_o = GLYPH_D;
         4'hE: seg_o = GLYPH_E;
         default: seg_o = GLYPH_F;
      endcase
      if (!hex_mode_i && (nibble_i > 4'd9)) seg_o = GLYPH_DASH;
   end

endmodule

// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode seven-segment scanner with double-buffered loading,
// leading-zero blanking, hex/decimal glyphs and PWM brightness. Pins are
// registered and follow the scan state with one cycle of latency.
module seven_segment_scanner
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int COUNT_PERIOD = 100000,
   parameter int PWM_BITS     = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   seven_segment_scanner_if.slave ld,
   input  logic                  hex_mode,
   input  logic                  blank_zeros,
   input  logic [PWM_BITS-1:0]   brightness,
   output logic [6:0]            cat,
   output logic                  dp_n,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  frame_tick
);

   localparam int                IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [31:0]       PRESC_LAST = 32'(COUNT_PERIOD - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [PWM_BITS-1:0] PWM_FULL = '1;

   logic [31:0]             presc_q, presc_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [PWM_BITS-1:0]     pwm_q, pwm_d;
   logic                    boundary;

   logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
   logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
   logic [NUM_DIGITS-1:0]   pend_en_q, pend_en_d, act_en_q, act_en_d;
   logic                    pend_full_q, pend_full_d;
   logic                    load_fire;

   logic [3:0]              sel_nib;
   logic                    sel_dp, sel_en, zero_from, blanked, lit, shown;
   logic [6:0]              glyph;

   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              cat_q, cat_d;
   logic                    dp_n_q, dp_n_d;
   logic                    tick_q, tick_d;

   // Scan timing: prescaler dwell per digit, digit index, free-running PWM
   always_comb begin
      boundary = (presc_q == PRESC_LAST) && (idx_q == IDX_LAST);
      presc_d  = presc_q + 32'd1;
      idx_d    = idx_q;
      if (presc_q == PRESC_LAST) begin
         presc_d = 32'd0;
         idx_d   = boundary ? '0 : idx_q + 1'b1;
      end
      pwm_d = pwm_q + 1'b1;
   end

   // Double buffer: accept into pending when empty, promote at frame boundary
   always_comb begin
      load_fire   = ld.load_valid && !pend_full_q;
      pend_val_d  = pend_val_q;
      pend_dp_d   = pend_dp_q;
      pend_en_d   = pend_en_q;
      act_val_d   = act_val_q;
      act_dp_d    = act_dp_q;
      act_en_d    = act_en_q;
      pend_full_d = pend_full_q;
      if (boundary && pend_full_q) begin
         act_val_d   = pend_val_q;
         act_dp_d    = pend_dp_q;
         act_en_d    = pend_en_q;
         pend_full_d = 1'b0;
      end
      // A load only fires when pending was empty, so it never races a promotion
      if (load_fire) begin
         pend_val_d  = ld.val_in;
         pend_dp_d   = ld.dp_in;
         pend_en_d   = ld.en_in;
         pend_full_d = 1'b1;
      end
   end

   assign ld.load_ready = !pend_full_q;

   // Select the current digit's data and decide leading-zero blanking
   always_comb begin
      sel_nib   = 4'd0;
      sel_dp    = 1'b0;
      sel_en    = 1'b0;
      zero_from = 1'b1;
      blanked   = 1'b0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_from = zero_from && (act_val_q[4*i +: 4] == 4'd0);
         if (IDX_W'(i) == idx_q) begin
            sel_nib = act_val_q[4*i +: 4];
            sel_dp  = act_dp_q[i];
            sel_en  = act_en_q[i];
            blanked = blank_zeros && (i != 0) && zero_from;
         end
      end
   end

   seg_glyph_decoder u_glyph (
      .nibble_i   (sel_nib),
      .hex_mode_i (hex_mode),
      .seg_o      (glyph)
   );

   // Next pin values: one anode low only when the digit is enabled, lit and not blanked
   always_comb begin
      lit    = (brightness == PWM_FULL) || (pwm_q < brightness);
      shown  = sel_en && lit && !blanked;
      an_d   = '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         an_d[i] = !(shown && (IDX_W'(i) == idx_q));
      end
      cat_d  = shown ? ~glyph : ~GLYPH_BLANK;
      dp_n_d = shown ? ~sel_dp : 1'b1;
      tick_d = boundary;
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= 32'd0;
         idx_q   <= '0;
         pwm_q   <= '0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         pwm_q   <= pwm_d;
      end
   end

   // Pending and active buffers; reset shows zeros on every digit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_val_q  <= '0;
         pend_dp_q   <= '0;
         pend_en_q   <= '0;
         pend_full_q <= 1'b0;
         act_val_q   <= '0;
         act_dp_q    <= '0;
         act_en_q    <= '1;
      end else begin
         pend_val_q  <= pend_val_d;
         pend_dp_q   <= pend_dp_d;
         pend_en_q   <= pend_en_d;
         pend_full_q <= pend_full_d;
         act_val_q   <= act_val_d;
         act_dp_q    <= act_dp_d;
         act_en_q    <= act_en_d;
      end
   end

   // Registered pin drivers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_q   <= '1;
         cat_q  <= 7'h7F;
         dp_n_q <= 1'b1;
         tick_q <= 1'b0;
      end else begin
         an_q   <= an_d;
         cat_q  <= cat_d;
         dp_n_q <= dp_n_d;
         tick_q <= tick_d;
      end
   end

   assign an         = an_q;
   assign cat        = cat_q;
   assign dp_n       = dp_n_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner (4 digits, 4-cycle dwell, 4-bit PWM).
// A reference model derives the scan position from the cycle count since
// reset and computes pins from the glyph letter lists.
module tb_seven_segment_scanner;

   localparam int ND    = 4;
   localparam int CP    = 4;
   localparam int PB    = 4;
   localparam int FRAME = ND * CP;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          hex_mode, blank_zeros;
   logic [PB-1:0] brightness;
   logic [6:0]    cat;
   logic          dp_n;
   logic [ND-1:0] an;
   logic          frame_tick;

   seven_segment_scanner_if #(.NUM_DIGITS(ND)) ld_if ();

   seven_segment_scanner #(
      .NUM_DIGITS   (ND),
      .COUNT_PERIOD (CP),
      .PWM_BITS     (PB)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ld          (ld_if),
      .hex_mode    (hex_mode),
      .blank_zeros (blank_zeros),
      .brightness  (brightness),
      .cat         (cat),
      .dp_n        (dp_n),
      .an          (an),
      .frame_tick  (frame_tick)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- reference model ----------------
   string glyph_str [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                             "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

   function automatic logic [6:0] segs(input string s);
      logic [6:0] r;
      r = '0;
      for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
      return r;
   endfunction

   int unsigned  k;
   logic [15:0]  m_val, p_val;
   logic [3:0]   m_dp, m_en, p_dp, p_en;
   bit           p_full;
   int           m_digit;
   logic [3:0]   m_nib;
   bit           m_lit, m_blank, m_fire;
   logic [3:0]   e_an;
   logic [6:0]   e_cat;
   logic         e_dpn, e_tick;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k = 0; m_val = '0; m_dp = '0; m_en = '1; p_full = 0;
         p_val = '0; p_dp = '0; p_en = '0;
         e_an = '1; e_cat = 7'h7F; e_dpn = 1'b1; e_tick = 1'b0;
      end else begin
         m_digit = int'((k / CP) % ND);
         m_nib   = m_val[4*m_digit +: 4];
         m_lit   = (brightness == 4'hF) || (int'(k % 16) < int'(brightness));
         m_blank = blank_zeros && (m_digit != 0) && ((m_val >> (4*m_digit)) == 16'd0);
         if (m_en[m_digit] && m_lit && !m_blank) begin
            e_an = '1;
            e_an[m_digit] = 1'b0;
            e_cat = ~((!hex_mode && m_nib > 4'd9) ? segs("g") : segs(glyph_str[m_nib]));
            e_dpn = !m_dp[m_digit];
         end else begin
            e_an = '1; e_cat = 7'h7F; e_dpn = 1'b1;
         end
         e_tick = ((k % FRAME) == FRAME - 1);
         m_fire = ld_if.load_valid && !p_full;
         if (e_tick && p_full) begin
            m_val = p_val; m_dp = p_dp; m_en = p_en; p_full = 0;
         end
         if (m_fire) begin
            p_val = ld_if.val_in; p_dp = ld_if.dp_in; p_en = ld_if.en_in; p_full = 1;
         end
         k++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
      ld_if.load_valid = 1'b1;
      ld_if.val_in     = v;
      ld_if.dp_in      = d;
      ld_if.en_in      = e;
   endtask

   task automatic drop_load();
      ld_if.load_valid = 1'b0;
   endtask

   task automatic set_mode(input logic hx, input logic bz, input logic [PB-1:0] br);
      hex_mode = hx; blank_zeros = bz; brightness = br;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({an, cat, dp_n, frame_tick, ld_if.load_ready} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_values: got %b want %b", {an, cat, dp_n, frame_tick, ld_if.load_ready},
                  {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_hex_scan();
      int ticks = 0;
      int f_seen = 0;
      set_mode(1'b1, 1'b0, 4'hF);
      drive_load(16'h12AF, 4'h0, 4'hF);
      for (int c = 0; c < 3 * FRAME; c++) begin
         @(negedge clk);
         drop_load();
         n_cmp++;
         if ({an, cat, dp_n, frame_tick, ld_if.load_ready} !== {e_an, e_cat, e_dpn, e_tick, !p_full}) begin
            n_bad++;
            $display("FAIL hex_scan cyc %0d: got %b want %b", c, {an, cat, dp_n, frame_tick, ld_if.load_ready},
                     {e_an, e_cat, e_dpn, e_tick, !p_full});
         end
         if (frame_tick) ticks++;
         if (c >= 2 * FRAME && an == 4'b1110 && cat == ~7'h71) f_seen++;
      end
      n_cmp++;
      if (ticks != 3) begin
         n_bad++;
         $display("FAIL hex_frame_ticks: got %0d want 3", ticks);
      end
      n_cmp++;
      if (f_seen != CP) begin
         n_bad++;
         $display("FAIL hex_digit0_F_dwell: got %0d want %0d", f_seen, CP);
      end
   endtask

   task automatic test_dash();
      int dash_seen = 0;
      set_mode(1'b0, 1'b0, 4'hF);
      for (int c = 0; c < 2 * FRAME; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({an, cat, dp_n, frame_tick, ld_if.load_ready} !== {e_an, e_cat, e_dpn, e_tick, !p_full}) begin
            n_bad++;
            $display("FAIL dash cyc %0d: got %b want %b", c, {an, cat, dp_n, frame_tick, ld_if.load_ready},
                     {e_an, e_cat, e_dpn, e_tick, !p_full});
         end
         if ((an == 4'b1110 || an == 4'b1101) && cat == 7'b0111111) dash_seen++;
      end
      n_cmp++;
      if (dash_seen != 4 * CP) begin
         n_bad++;
         $display("FAIL dash_count: got %0d want %0d", dash_seen, 4 * CP);
      end
   endtask

   task automatic test_blank();
      int upper_on = 0;
      set_mode(1'b1, 1'b1, 4'hF);
      drive_load(16'h0050, 4'h2, 4'hF);
      for (int c = 0; c < 3 * FRAME; c++) begin
         @(negedge clk);
         drop_load();
         n_cmp++;
         if ({an, cat, dp_n, frame_tick, ld_if.load_ready} !== {e_an, e_cat, e_dpn, e_tick, !p_full}) begin
            n_bad++;
            $display("FAIL blank cyc %0d: got %b want %b", c, {an, cat, dp_n, frame_tick, ld_if.load_ready},
                     {e_an, e_cat, e_dpn, e_tick, !p_full});
         end
         if (c >= 2 * FRAME && (an[3] == 1'b0 || an[2] == 1'b0)) upper_on++;
      end
      n_cmp++;
      if (upper_on != 0) begin
         n_bad++;
         $display("FAIL blank_upper_digits: got %0d lit cycles want 0", upper_on);
      end
   endtask

   task automatic test_back_to_back();
      set_mode(1'b1, 1'b0, 4'hF);
      drive_load(16'h1111, 4'h0, 4'hF);
      @(negedge clk);
      n_cmp++;
      if (ld_if.load_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_ready_low: got %b want 0", ld_if.load_ready);
      end
      drive_load(16'h2222, 4'h5, 4'hF);
      for (int c = 0; c < 3 * FRAME; c++) begin
         @(negedge clk);
         if (ld_if.load_ready) drop_load();
         n_cmp++;
         if ({an, cat, dp_n, frame_tick, ld_if.load_ready} !== {e_an, e_cat, e_dpn, e_tick, !p_full}) begin
            n_bad++;
            $display("FAIL b2b cyc %0d: got %b want %b", c, {an, cat, dp_n, frame_tick, ld_if.load_ready},
                     {e_an, e_cat, e_dpn, e_tick, !p_full});
         end
      end
      @(negedge clk);
      drop_load();
   endtask

   task automatic test_pwm();
      int on_cnt;
      set_mode(1'b1, 1'b0, 4'd4);
      drive_load(16'h8888, 4'h0, 4'hF);
      @(negedge clk);
      drop_load();
      repeat (2 * FRAME) @(negedge clk);
      on_cnt = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({an, cat, dp_n} !== {e_an, e_cat, e_dpn}) begin
            n_bad++;
            $display("FAIL pwm4 cyc %0d: got %b want %b", c, {an, cat, dp_n}, {e_an, e_cat, e_dpn});
         end
         if (an != 4'hF) on_cnt++;
      end
      n_cmp++;
      if (on_cnt != 4) begin
         n_bad++;
         $display("FAIL pwm4_on_cycles: got %0d want 4", on_cnt);
      end
      brightness = 4'd0;
      @(negedge clk);
      on_cnt = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (an != 4'hF) on_cnt++;
      end
      n_cmp++;
      if (on_cnt != 0) begin
         n_bad++;
         $display("FAIL pwm0_on_cycles: got %0d want 0", on_cnt);
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 8; r++) begin
         set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         for (int c = 0; c < 40; c++) begin
            if ($urandom_range(0, 3) == 0)
               drive_load(16'($urandom), 4'($urandom), 4'($urandom));
            else
               drop_load();
            @(negedge clk);
            n_cmp++;
            if ({an, cat, dp_n, frame_tick, ld_if.load_ready} !== {e_an, e_cat, e_dpn, e_tick, !p_full}) begin
               n_bad++;
               $display("FAIL random r%0d cyc %0d: got %b want %b", r, c,
                        {an, cat, dp_n, frame_tick, ld_if.load_ready}, {e_an, e_cat, e_dpn, e_tick, !p_full});
            end
         end
      end
      drop_load();
   endtask

   task automatic test_reset_mid();
      int zero_seen = 0;
      set_mode(1'b1, 1'b0, 4'hF);
      drive_load(16'h9999, 4'hF, 4'hF);
      @(negedge clk);
      drop_load();
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({an, cat, dp_n, frame_tick, ld_if.load_ready} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL reset_mid_pins: got %b want %b", {an, cat, dp_n, frame_tick, ld_if.load_ready},
                  {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 2 * FRAME; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({an, cat, dp_n, frame_tick, ld_if.load_ready} !== {e_an, e_cat, e_dpn, e_tick, !p_full}) begin
            n_bad++;
            $display("FAIL reset_mid cyc %0d: got %b want %b", c, {an, cat, dp_n, frame_tick, ld_if.load_ready},
                     {e_an, e_cat, e_dpn, e_tick, !p_full});
         end
         if (c < CP && an == 4'b1110 && cat == ~7'h3F && dp_n == 1'b1 && ld_if.load_ready) zero_seen++;
      end
      n_cmp++;
      if (zero_seen != CP) begin
         n_bad++;
         $display("FAIL reset_mid_digit0_zero: got %0d want %0d", zero_seen, CP);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst_n = 1'b0;
      ld_if.load_valid = 1'b0;
      ld_if.val_in = '0;
      ld_if.dp_in = '0;
      ld_if.en_in = '0;
      set_mode(1'b1, 1'b0, 4'hF);
      test_reset();
      test_hex_scan();
      test_dash();
      test_blank();
      test_back_to_back();
      test_pwm();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
